// File: rtl/mem_port_responder.sv
// Memory-side responder for the CPU memory port: programmable wait states, 16-bit word array, one-cycle ready.
// Optional out-of-range detection on address bits [15:ADDR_W] is enabled by defining MEM_RESP_ERR_EN.
module mem_port_responder #(
   parameter int DATA_W      = 16,
   parameter int ADDR_W      = 12,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              we,
   input  logic [15:0]       addr,
   input  logic [DATA_W-1:0] wd,
   output logic [DATA_W-1:0] rd,
   output logic              ready,
   output logic              busy,
   output logic              err
);

   localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t              state;
   logic [CNT_W-1:0]    cnt;
   logic                we_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wd_q;
   logic                oor_q;

   logic [DATA_W-1:0]   mem [2**ADDR_W];

   logic                acc_fire;
   logic                acc_we;
   logic                acc_oor;
   logic [ADDR_W-1:0]   acc_idx;
   logic [DATA_W-1:0]   acc_wd;
   logic [DATA_W-1:0]   acc_rd;
   logic                addr_oor;

`ifdef MEM_RESP_ERR_EN
   assign addr_oor = |addr[15:ADDR_W];
`else
   logic unused_addr_hi;
   assign unused_addr_hi = ^addr[15:ADDR_W];
   assign addr_oor       = 1'b0;
`endif

   // With zero wait states the access uses the live request on the capture edge.
   always_comb begin
      acc_fire = 1'b0;
      acc_we   = we_q;
      acc_idx  = addr_q;
      acc_wd   = wd_q;
      acc_oor  = oor_q;
      if (WAIT_CYCLES == 0) begin
         acc_fire = rst && (state == S_IDLE) && req;
         acc_we   = we;
         acc_idx  = addr[ADDR_W-1:0];
         acc_wd   = wd;
         acc_oor  = addr_oor;
      end else begin
         acc_fire = rst && (state == S_WAIT) && (cnt == '0);
      end
   end

   always_comb begin
      acc_rd = '0;
      if (!acc_oor)
         acc_rd = acc_we ? acc_wd : mem[acc_idx];
   end

   // Array is deliberately not reset; only landed accesses modify it.
   always_ff @(posedge clk) begin
      if (acc_fire && acc_we && !acc_oor)
         mem[acc_idx] <= acc_wd;
   end

`ifdef MEM_RESP_ERR_EN
   logic err_q;
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= S_IDLE;
         cnt    <= '0;
         we_q   <= 1'b0;
         addr_q <= '0;
         wd_q   <= '0;
         oor_q  <= 1'b0;
         rd     <= '0;
         ready  <= 1'b0;
         busy   <= 1'b0;
`ifdef MEM_RESP_ERR_EN
         err_q  <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (req) begin
                  we_q   <= we;
                  addr_q <= addr[ADDR_W-1:0];
                  wd_q   <= wd;
                  oor_q  <= addr_oor;
                  busy   <= 1'b1;
                  cnt    <= CNT_LOAD;
                  if (acc_fire) begin
                     rd    <= acc_rd;
                     ready <= 1'b1;
`ifdef MEM_RESP_ERR_EN
                     err_q <= acc_oor;
`endif
                     state <= S_RESP;
                  end else begin
                     state <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (acc_fire) begin
                  rd    <= acc_rd;
                  ready <= 1'b1;
`ifdef MEM_RESP_ERR_EN
                  err_q <= acc_oor;
`endif
                  state <= S_RESP;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            S_RESP: begin
               ready <= 1'b0;
               busy  <= 1'b0;
`ifdef MEM_RESP_ERR_EN
               err_q <= 1'b0;
`endif
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_responder.sv
// Testbench for mem_port_responder: directed and random accesses on a 2-wait-state and a zero-wait instance.
module tb_mem_port_responder;

   localparam int WA = 2;
   localparam int WB = 0;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_a, we_a, req_b, we_b;
   logic [15:0] addr_a, wd_a, addr_b, wd_b;
   logic [15:0] rd_a, rd_b;
   logic        ready_a, busy_a, err_a, ready_b, busy_b, err_b;

   int checks = 0;
   int errors = 0;

   logic [15:0] model [4096];
   logic [11:0] written [$];

   always #5 clk = ~clk;

   mem_port_responder #(.DATA_W(16), .ADDR_W(12), .WAIT_CYCLES(WA)) u_dut_a (
      .clk(clk), .rst(rst), .req(req_a), .we(we_a), .addr(addr_a), .wd(wd_a),
      .rd(rd_a), .ready(ready_a), .busy(busy_a), .err(err_a)
   );

   mem_port_responder #(.DATA_W(16), .ADDR_W(12), .WAIT_CYCLES(WB)) u_dut_b (
      .clk(clk), .rst(rst), .req(req_b), .we(we_b), .addr(addr_b), .wd(wd_b),
      .rd(rd_b), .ready(ready_b), .busy(busy_b), .err(err_b)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic o_ready(input bit s);
      return s ? ready_b : ready_a;
   endfunction
   function automatic logic o_busy(input bit s);
      return s ? busy_b : busy_a;
   endfunction
   function automatic logic o_err(input bit s);
      return s ? err_b : err_a;
   endfunction
   function automatic logic [15:0] o_rd(input bit s);
      return s ? rd_b : rd_a;
   endfunction

   task automatic drive(input bit s, input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
      if (s) begin
         req_b = r; we_b = w; addr_b = a; wd_b = d;
      end else begin
         req_a = r; we_a = w; addr_a = a; wd_a = d;
      end
   endtask

   // Expected response from the array rules; updates the model for landed writes.
   task automatic model_step(input logic w, input logic [15:0] a, input logic [15:0] d,
                             output logic [15:0] r, output logic e);
      bit oor;
`ifdef MEM_RESP_ERR_EN
      oor = (a[15:12] != 4'h0);
`else
      oor = 1'b0;
`endif
      if (oor) begin
         r = 16'h0; e = 1'b1;
      end else if (w) begin
         model[a[11:0]] = d; r = d; e = 1'b0;
      end else begin
         r = model[a[11:0]]; e = 1'b0;
      end
   endtask

   // Issues one request (req dropped after the capture edge) and observes the response.
   task automatic access(input bit s, input logic w, input logic [15:0] a, input logic [15:0] d,
                         output logic [15:0] r, output logic e, output int lat, output int bcnt,
                         output logic tail);
      drive(s, 1'b1, w, a, d);
      lat = 0; bcnt = 0; r = 'x; e = 'x;
      for (int i = 1; i <= 20 && lat == 0; i++) begin
         @(negedge clk);
         if (i == 1) drive(s, 1'b0, w, a, d);
         if (o_busy(s)) bcnt++;
         if (o_ready(s)) begin
            lat = i; r = o_rd(s); e = o_err(s);
         end
      end
      @(negedge clk);
      tail = o_ready(s) | o_busy(s);
   endtask

   task automatic do_checked(input string tag, input bit s, input logic w, input logic [15:0] a,
                             input logic [15:0] d, input logic [15:0] er, input logic ee);
      logic [15:0] r;
      logic e, tail;
      int lat, bcnt, wc;
      wc = s ? WB : WA;
      access(s, w, a, d, r, e, lat, bcnt, tail);
      check({tag, "/latency"}, lat, wc + 1);
      check({tag, "/busy_cycles"}, bcnt, wc + 1);
      check({tag, "/rd"}, r, er);
      check({tag, "/err"}, e, ee);
      check({tag, "/pulse_end"}, tail, 1'b0);
   endtask

   task automatic model_access(input string tag, input logic w, input logic [15:0] a, input logic [15:0] d);
      logic [15:0] er;
      logic ee;
      model_step(w, a, d, er, ee);
      do_checked(tag, 1'b0, w, a, d, er, ee);
   endtask

   initial begin
      int nrdy, first, last;
      logic [15:0] lrd, a, d;
      logic [3:0] pat;

      drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
      drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("reset/a", {rd_a, ready_a, busy_a, err_a}, 19'h0);
      check("reset/b", {rd_b, ready_b, busy_b, err_b}, 19'h0);
      rst = 1'b1;
      @(negedge clk);

      model_access("wr005", 1'b1, 16'h0005, 16'hBEEF);
      model_access("rd005", 1'b0, 16'h0005, 16'h0000);

      // Request held high: captures only from IDLE, one response per WA+2 cycles.
      drive(1'b0, 1'b1, 1'b0, 16'h0005, 16'h0);
      nrdy = 0; first = 0; last = 0; lrd = '0;
      for (int i = 1; i <= 3 * (WA + 2); i++) begin
         @(negedge clk);
         if (ready_a) begin
            nrdy++;
            if (first == 0) first = i;
            last = i;
            lrd = rd_a;
         end
      end
      drive(1'b0, 1'b0, 1'b0, 16'h0005, 16'h0);
      check("held/count", nrdy, 3);
      check("held/first", first, WA + 1);
      check("held/last", last, WA + 1 + 2 * (WA + 2));
      check("held/rd", lrd, 16'hBEEF);
      repeat (2) @(negedge clk);
      check("held/idle", {ready_a, busy_a}, 2'b00);

      // Reset pulse while the re-write is waiting: the write must not land.
      model_access("wr010", 1'b1, 16'h0010, 16'h1234);
      drive(1'b0, 1'b1, 1'b1, 16'h0010, 16'hAAAA);
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
      check("abort/busy_before", busy_a, 1'b1);
      #2 rst = 1'b0;
      #1;
      check("abort/async_a", {rd_a, ready_a, busy_a, err_a}, 19'h0);
      check("abort/async_b", {rd_b, ready_b, busy_b, err_b}, 19'h0);
      @(negedge clk);
      rst = 1'b1;
      nrdy = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (ready_a) nrdy++;
      end
      check("abort/no_ready", nrdy, 0);
      model_access("rd010", 1'b0, 16'h0010, 16'h0);

      // Zero wait states: preload, then back-to-back reads.
      do_checked("b_wr000", 1'b1, 1'b1, 16'h0000, 16'h0001, 16'h0001, 1'b0);
      do_checked("b_wr001", 1'b1, 1'b1, 16'h0001, 16'h0002, 16'h0002, 1'b0);
      drive(1'b1, 1'b1, 1'b0, 16'h0000, 16'h0);
      pat = '0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         pat[3-i] = ready_b;
         if (i == 0) begin
            check("b2b/rd0", rd_b, 16'h0001);
            drive(1'b1, 1'b1, 1'b0, 16'h0001, 16'h0);
         end
         if (i == 2) begin
            check("b2b/rd1", rd_b, 16'h0002);
            drive(1'b1, 1'b0, 1'b0, 16'h0001, 16'h0);
         end
      end
      check("b2b/ready_pattern", pat, 4'b1010);

      // Upper address bits: alias without the range check, rejected with it.
      model_access("pre003", 1'b1, 16'h0003, 16'h3333);
      model_access("wr1003", 1'b1, 16'h1003, 16'h5555);
      model_access("rd0003", 1'b0, 16'h0003, 16'h0);
      model_access("rd1003", 1'b0, 16'h1003, 16'h0);

      for (int i = 0; i < 12; i++) begin
         a = 16'($urandom_range(0, 65535));
         d = 16'($urandom_range(0, 65535));
         written.push_back(a[11:0]);
         model_access($sformatf("rnd_wr%0d", i), 1'b1, a, d);
      end
      for (int i = 0; i < 12; i++) begin
         a = {4'($urandom_range(0, 15)), written[$urandom_range(0, written.size() - 1)]};
         model_access($sformatf("rnd_rd%0d", i), 1'b0, a, 16'h0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
